// File: rtl/fsm_pattern_tx_pkg.sv
// Shared state encoding and counter-sizing helpers for the fsm_pattern_tx serial pattern generator.
// The optional parity bit is enabled by defining FSM_PATTERN_TX_PARITY_EN.
package fsm_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 2;

`ifdef FSM_PATTERN_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits needed for a counter that must reach maxval; never narrower than one bit.
  function automatic int cnt_bits(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/fsm_pattern_tx_pattern_shreg.sv
// Loadable left-shift register with a bit counter; last flags the final bit of the frame.
module pattern_shreg
  import fsm_pattern_pkg::*;
#(
  parameter int FLEN = 8
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            load,
  input  logic            shift,
  input  logic [FLEN-1:0] din,
  output logic            msb,
  output logic            last
);

  localparam int            BW       = cnt_bits(FLEN - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(FLEN - 1);

  logic [FLEN-1:0] shreg;
  logic [BW-1:0]   bitcnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= din;
      bitcnt <= '0;
    end else if (shift) begin
      shreg  <= {shreg[FLEN-2:0], 1'b0};
      bitcnt <= bitcnt + BW'(1);
    end
  end

  assign msb  = shreg[FLEN-1];
  assign last = (bitcnt == LAST_IDX);

endmodule

// File: rtl/fsm_pattern_tx.sv
// Moore serial pattern generator: sends a captured pattern MSB-first on w, repeated with idle gaps.
// Define FSM_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module fsm_pattern_tx
  import fsm_pattern_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               FLEN     = WIDTH + PARITY_BITS;
  localparam int               GAP_MAX  = (GAP > 0) ? GAP - 1 : 0;
  localparam int               GW       = cnt_bits(GAP_MAX);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_MAX);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic             NO_GAP   = (GAP == 0);

  state_t           state;
  logic [FLEN-1:0]  frame_in;
  logic [FLEN-1:0]  frame_q;
  logic [FLEN-1:0]  load_data;
  logic [CNT_W-1:0] reps;
  logic [GW-1:0]    gapcnt;
  logic             accept;
  logic             more;
  logic             gap_end;
  logic             load;
  logic             shift;
  logic             bit_msb;
  logic             bit_last;

`ifdef FSM_PATTERN_TX_PARITY_EN
  assign frame_in = {pattern, ^pattern};
`else
  assign frame_in = pattern;
`endif

  // The first load comes straight from the inputs; every repeat reloads from the captured copy.
  assign accept    = (state == ST_IDLE) && start;
  assign more      = (reps > ONE);
  assign gap_end   = (state == ST_GAP) && (gapcnt == GAP_LAST);
  assign load      = accept || gap_end || (NO_GAP && (state == ST_SHIFT) && bit_last && more);
  assign shift     = (state == ST_SHIFT) && !bit_last;
  assign load_data = accept ? frame_in : frame_q;

  pattern_shreg #(
    .FLEN(FLEN)
  ) u_shreg (
    .Clock (Clock),
    .Resetn(Resetn),
    .load  (load),
    .shift (shift),
    .din   (load_data),
    .msb   (bit_msb),
    .last  (bit_last)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_IDLE;
      frame_q <= '0;
      reps    <= '0;
      gapcnt  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            frame_q <= frame_in;
            reps    <= (repeat_n == '0) ? ONE : repeat_n;
            valid   <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_last) begin
            if (more && NO_GAP) begin
              reps <= reps - ONE;
            end else if (more) begin
              gapcnt <= '0;
              valid  <= 1'b0;
              state  <= ST_GAP;
            end else begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            reps  <= reps - ONE;
            valid <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            gapcnt <= gapcnt + GW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // valid is low outside SHIFT, so w can never show stale shift-register contents.
  assign w = valid & bit_msb;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Testbench for fsm_pattern_tx: table-driven jobs, hand-written corner sequences and random jobs,
// all checked cycle by cycle against a frame-level reference model.
module tb_fsm_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
`ifdef FSM_PATTERN_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             Clock = 1'b0;
  logic             Resetn = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic             w;
  logic             valid;
  logic             busy;
  logic             done;

  int nCompared = 0;
  int nMismatched = 0;

  // Expected per-cycle outputs packed as {w, valid, busy, done}.
  logic [3:0] expQ[$];

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic [CNT_W-1:0] rep;
    bit               noise;
    int               busyLen;
  } vec_t;

  vec_t vecs[8];

  always #5 Clock = ~Clock;

  fsm_pattern_tx #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .GAP  (GAP)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start   (start),
    .pattern (pattern),
    .repeat_n(repeat_n),
    .w       (w),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  function automatic int busyCycles(input logic [CNT_W-1:0] rep);
    int r;
    r = (rep == '0) ? 1 : int'(rep);
    return r * FLEN + (r - 1) * GAP;
  endfunction

  // Frame-level model: R copies of the pattern bits (plus parity), GAP idle cycles between them,
  // one done cycle, then one idle cycle.
  function automatic void modelJob(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
    int r;
    r = (rep == '0) ? 1 : int'(rep);
    for (int f = 0; f < r; f++) begin
      for (int b = WIDTH - 1; b >= 0; b--) expQ.push_back({pat[b], 1'b1, 1'b1, 1'b0});
`ifdef FSM_PATTERN_TX_PARITY_EN
      expQ.push_back({^pat, 1'b1, 1'b1, 1'b0});
`endif
      if (f < r - 1)
        for (int g = 0; g < GAP; g++) expQ.push_back(4'b0010);
    end
    expQ.push_back(4'b0001);
    expQ.push_back(4'b0000);
  endfunction

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
    start    = s;
    pattern  = pat;
    repeat_n = rep;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [3:0] exp);
    logic [3:0] got;
    got = {w, valid, busy, done};
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s cycle %0d: got w/valid/busy/done=%b required %b", name, cyc, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; start is accepted on the next posedge.
  task automatic runJob(input string name, input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep,
                        input bit noise, input int expBusy);
    int n;
    int busyCnt;
    busyCnt = 0;
    expQ.delete();
    modelJob(pat, rep);
    n = expQ.size();
    applyStimulus(1'b1, pat, rep);
    @(posedge Clock);
    #1;
    applyStimulus(1'b0, WIDTH'($urandom), CNT_W'($urandom));
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      checkOutput(name, i, expQ[i]);
      if (busy === 1'b1) busyCnt++;
      if (noise && i < n - 1)
        applyStimulus(1'($urandom), WIDTH'($urandom), CNT_W'($urandom));
      else
        start = 1'b0;
    end
    checkValue({name, "_busylen"}, busyCnt, expBusy);
  endtask

  initial begin
    int n;
    int firstLen;

    vecs[0] = '{pat: 8'hB2, rep: 4'd1,  noise: 1'b0, busyLen: FLEN};
    vecs[1] = '{pat: 8'hB2, rep: 4'd3,  noise: 1'b0, busyLen: 3 * FLEN + 2 * GAP};
    vecs[2] = '{pat: 8'h0F, rep: 4'd0,  noise: 1'b0, busyLen: FLEN};
    vecs[3] = '{pat: 8'hFF, rep: 4'd2,  noise: 1'b1, busyLen: 2 * FLEN + GAP};
    vecs[4] = '{pat: 8'h00, rep: 4'd1,  noise: 1'b0, busyLen: FLEN};
    vecs[5] = '{pat: 8'hB3, rep: 4'd1,  noise: 1'b0, busyLen: FLEN};
    vecs[6] = '{pat: 8'h81, rep: 4'd15, noise: 1'b1, busyLen: 15 * FLEN + 14 * GAP};
    vecs[7] = '{pat: 8'hA5, rep: 4'd4,  noise: 1'b1, busyLen: 4 * FLEN + 3 * GAP};

    #2 Resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      checkOutput("reset_hold", i, 4'b0000);
      applyStimulus(~start, WIDTH'($urandom), CNT_W'($urandom));
    end
    start  = 1'b0;
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checkOutput("idle_after_reset", i, 4'b0000);
    end

    for (int v = 0; v < 8; v++)
      runJob($sformatf("vec%0d", v), vecs[v].pat, vecs[v].rep, vecs[v].noise, vecs[v].busyLen);

    // start held high while pattern changes: the captured 8'hB2 must go out untouched,
    // then 8'h0F starts one idle cycle after done.
    expQ.delete();
    modelJob(8'hB2, 4'd1);
    firstLen = expQ.size();
    modelJob(8'h0F, 4'd1);
    n = expQ.size();
    applyStimulus(1'b1, 8'hB2, 4'd1);
    @(posedge Clock);
    #1 pattern = 8'h0F;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      checkOutput("held_start", i, expQ[i]);
      if (i >= firstLen) start = 1'b0;
    end

    // Reset asserted while bit 4 of the first frame is on the line.
    expQ.delete();
    modelJob(8'hB2, 4'd2);
    applyStimulus(1'b1, 8'hB2, 4'd2);
    @(posedge Clock);
    #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      checkOutput("pre_abort", i, expQ[i]);
    end
    Resetn = 1'b0;
    #1 checkOutput("abort_async", 0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checkOutput("abort_hold", i, 4'b0000);
      start = ~start;
    end
    start  = 1'b0;
    Resetn = 1'b1;
    @(negedge Clock);
    checkOutput("abort_no_done", 0, 4'b0000);
    runJob("after_abort_rep0", 8'h5A, 4'd0, 1'b0, FLEN);

    for (int j = 0; j < 12; j++) begin
      logic [WIDTH-1:0] rp;
      logic [CNT_W-1:0] rr;
      rp = WIDTH'($urandom);
      rr = CNT_W'($urandom_range(0, 5));
      runJob($sformatf("rand%0d", j), rp, rr, 1'b1, busyCycles(rr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fsm_pattern_tx.md
# fsm_pattern_tx

Moore-style serial pattern generator: captures a WIDTH-bit pattern on a start request and drives it MSB-first, one bit per clock, on the serial line `w`. The pattern repeats a programmed number of times with idle gap cycles between frames. It is the transmit side of the serial `w` interface consumed by the team's Moore sequence-detector FSMs, and it serves as both stimulus source and production pattern driver.

## Interface
- WIDTH, 8: pattern length in bits (≥2).
- CNT_W, 4: width of repeat count.
- GAP, 2: idle cycles between repeated frames (0 allowed).
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- pattern  in  WIDTH  frame bits; captured when start is accepted.
- repeat_n  in  CNT_W  number of frames; 0 is treated as 1; captured with pattern.
- w  out  1  serial data, MSB first.
- valid  out  1  high while `w` carries a frame bit.
- busy  out  1  high in SHIFT and GAP.
- done  out  1  one-cycle pulse after the last frame.

## Operation
- Reset: w=0, valid=0, busy=0, done=0, state=IDLE. Shift register, bit counter and repeat counter are cleared.
- States (Moore; outputs decode from registered state/datapath only, with no input-to-output combinational path):
  - IDLE: all outputs 0. start=1 → capture pattern, repeat_n(0→1), bit count=0 → SHIFT.
  - SHIFT: w=shreg[MSB], valid=1, busy=1. Shift left each cycle. After bit WIDTH-1: reps left>1 → GAP (or straight to SHIFT with reload if GAP=0); otherwise → DONE.
  - GAP: w=0, valid=0, busy=1 for exactly GAP cycles. Decrement reps and reload shreg from the captured pattern, then → SHIFT.
  - DONE: done=1, busy=0, w=0 for one cycle → IDLE.
  - Unused encoding → IDLE. Never drive x.
- start is ignored in SHIFT/GAP/DONE. Changes to pattern or repeat_n after capture have no effect.
- Reset mid-operation aborts immediately to the reset values. No done pulse.

## Timing
- start high at edge k → first bit on w in the cycle after edge k (latency 1).
- Busy duration = R·WIDTH + (R−1)·GAP cycles, with R=max(repeat_n,1). done is asserted in the cycle following the last bit.
- Next start is accepted no earlier than the edge after DONE, giving 1 idle cycle minimum between jobs.

## Configuration
- FSM_PATTERN_TX_PARITY_EN defined: each frame is followed by one even-parity bit (XOR of pattern) with valid=1, giving frame length WIDTH+1. All timing formulas use WIDTH+1.
- Undefined: frame is exactly WIDTH bits, with no parity logic.

## Structure
- Package fsm_pattern_pkg holds the state encodings (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the gap/bit counter width helper constants.
- Sub-module pattern_shreg: loadable left-shift register plus bit counter with a last-bit flag. The top module holds the FSM, repeat/gap counters and parity.

## Test plan
- Reset: Resetn low with start toggling → w=0, valid=0, busy=0, done=0. Release, no start → outputs stay 0.
- WIDTH=8, pattern=8'hB2, repeat_n=1, one-cycle start → w=1,0,1,1,0,0,1,0 with valid=1 for 8 cycles and busy 8 cycles, then done=1 for 1 cycle.
- repeat_n=3, GAP=2, pattern=8'hB2 → three identical frames, each separated by 2 cycles with w=0/valid=0. busy lasts 28 cycles, followed by a single done pulse.
- start held high and pattern changed to 8'h0F mid-frame → output remains 8'hB2. A new job begins only after DONE (first bit of 8'h0F one cycle after IDLE).
- Resetn pulsed low at bit 4 of a frame → w, valid and busy drop asynchronously, with no done. A subsequent start transmits a full frame correctly. repeat_n=0 produces exactly one frame.
- With FSM_PATTERN_TX_PARITY_EN: 8'hB2 → 9th bit 0; 8'hB3 → 9th bit 1; valid high for 9 cycles.
